// File: rtl/mips_cp0_pkg.sv
// Shared constants for the MIPS64 coprocessor-0 block.
// Register numbers, field positions and exception codes.
package mips_cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int IE_BIT  = 0;
    localparam int EXL_BIT = 1;
    localparam int IM_LO   = 8;
    localparam int IM_HI   = 15;
    localparam int IP_LO   = 8;
    localparam int IP_HI   = 15;
    localparam int EXC_LO  = 2;
    localparam int EXC_HI  = 6;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

endpackage

// File: rtl/mips_cp0_if.sv
// MEM-stage side bus between the pipeline and coprocessor 0.
// The pipeline is master; the CP0 block is slave.
interface mips_cp0_if;
    logic [63:0] rd_data;
    logic [63:0] EPC;
    logic        TakenInterrupt;
    logic [63:0] wr_data;
    logic [4:0]  regnum;
    logic [2:0]  sel;
    logic [63:0] next_pc;
    logic        MTC0;
    logic        ERET;
    logic [7:0]  interrupt_sources;
    logic        overflow;
    logic        reserved_inst;
    logic        syscall;
    logic        break_inst;

    modport master (
        input  rd_data, EPC, TakenInterrupt,
        output wr_data, regnum, sel, next_pc, MTC0, ERET,
        output interrupt_sources, overflow, reserved_inst,
        output syscall, break_inst
    );

    modport slave (
        output rd_data, EPC, TakenInterrupt,
        input  wr_data, regnum, sel, next_pc, MTC0, ERET,
        input  interrupt_sources, overflow, reserved_inst,
        input  syscall, break_inst
    );
endinterface

// File: rtl/mips_cp0_exc_encoder.sv
// Priority encoder: fault lines and pending interrupt to ExcCode.
// Faults are masked while EXL is set.
module cp0_exc_encoder
    import mips_cp0_pkg::*;
(
    input  logic       overflow,
    input  logic       reserved_inst,
    input  logic       syscall,
    input  logic       break_inst,
    input  logic       int_pend,
    input  logic       exl,
    output logic       taken,
    output logic [4:0] exc_code
);

    logic fault;

    assign fault = (overflow | reserved_inst | syscall | break_inst) & ~exl;
    assign taken = fault | int_pend;

    // Items are made mutually exclusive to encode the priority order.
    always_comb begin
        exc_code = EXC_INT;
        unique case (1'b1)
            reserved_inst:
                exc_code = EXC_RI;
            syscall & ~reserved_inst:
                exc_code = EXC_SYS;
            break_inst & ~reserved_inst & ~syscall:
                exc_code = EXC_BP;
            overflow & ~reserved_inst & ~syscall & ~break_inst:
                exc_code = EXC_OV;
            default:
                exc_code = EXC_INT;
        endcase
    end

endmodule

// File: rtl/mips_cp0.sv
// Coprocessor-0 Status/Cause/EPC registers and exception control.
// Reads and the take-handler decision are combinational.
module mips_cp0
    import mips_cp0_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    mips_cp0_if.slave   bus
);

    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic [7:0]  ip;
    logic [4:0]  exc_code;
    logic [63:0] epc;

    logic        int_pend;
    logic        taken;
    logic [4:0]  next_code;
    logic        sel0;
    logic        wr_status;
    logic        wr_epc;
    logic [31:0] status_w;
    logic [31:0] cause_w;

    assign int_pend = (|(ip & im)) & ie & ~exl;

    cp0_exc_encoder u_enc (
        .overflow      (bus.overflow),
        .reserved_inst (bus.reserved_inst),
        .syscall       (bus.syscall),
        .break_inst    (bus.break_inst),
        .int_pend      (int_pend),
        .exl           (exl),
        .taken         (taken),
        .exc_code      (next_code)
    );

    assign sel0      = (bus.sel == 3'd0);
    assign wr_status = bus.MTC0 & sel0 & (bus.regnum == CP0_STATUS);
    assign wr_epc    = bus.MTC0 & sel0 & (bus.regnum == CP0_EPC);

    assign status_w = {16'd0, im, 6'd0, exl, ie};
    assign cause_w  = {16'd0, ip, 1'b0, exc_code, 2'd0};

    always_comb begin
        bus.rd_data = 64'd0;
        if (sel0) begin
            unique case (bus.regnum)
                CP0_STATUS: bus.rd_data = {32'd0, status_w};
                CP0_CAUSE:  bus.rd_data = {32'd0, cause_w};
                CP0_EPC:    bus.rd_data = epc;
                default:    bus.rd_data = 64'd0;
            endcase
        end
    end

    assign bus.EPC            = epc;
    assign bus.TakenInterrupt = taken;

    // Later assignments win: exception overrides MTC0 for EXL and EPC.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            im       <= 8'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            ip       <= 8'd0;
            exc_code <= 5'd0;
            epc      <= 64'd0;
        end else begin
            ip <= bus.interrupt_sources;
            if (wr_status) begin
                im  <= bus.wr_data[IM_HI:IM_LO];
                exl <= bus.wr_data[EXL_BIT];
                ie  <= bus.wr_data[IE_BIT];
            end
            if (wr_epc)
                epc <= bus.wr_data;
            if (taken) begin
                exl      <= 1'b1;
                epc      <= bus.next_pc;
                exc_code <= next_code;
            end else if (bus.ERET) begin
                exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_cp0.sv
// Directed bench for mips_cp0 with an expected-value queue.
// Expectations are queued as stimulus is applied, then popped on check.
module tb_mips_cp0;

    logic clock;
    logic reset;

    mips_cp0_if bus ();

    mips_cp0 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    task automatic want(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty obs=%h", obs);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            assert (obs === e.val)
            else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [4:0] r, input logic [2:0] s,
                      output logic [63:0] v);
        bus.regnum = r;
        bus.sel    = s;
        #1;
        v = bus.rd_data;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [2:0] s,
                        input logic [63:0] d);
        bus.regnum  = r;
        bus.sel     = s;
        bus.wr_data = d;
        bus.MTC0    = 1'b1;
        tick();
        bus.MTC0    = 1'b0;
        bus.sel     = 3'd0;
    endtask

    logic [63:0] v;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.wr_data           = 64'd0;
        bus.regnum            = 5'd0;
        bus.sel               = 3'd0;
        bus.next_pc           = 64'd0;
        bus.MTC0              = 1'b0;
        bus.ERET              = 1'b0;
        bus.interrupt_sources = 8'd0;
        bus.overflow          = 1'b0;
        bus.reserved_inst     = 1'b0;
        bus.syscall           = 1'b0;
        bus.break_inst        = 1'b0;
        #12;
        reset = 1'b0;

        want("rst_status", 64'd0); rd(5'd12, 3'd0, v); check(v);
        want("rst_cause",  64'd0); rd(5'd13, 3'd0, v); check(v);
        want("rst_epc",    64'd0); rd(5'd14, 3'd0, v); check(v);
        want("rst_taken",  64'd0); check({63'd0, bus.TakenInterrupt});

        mtc0(5'd12, 3'd0, 64'hFF01);
        want("status_ff01", 64'hFF01); rd(5'd12, 3'd0, v); check(v);
        want("taken_no_ip", 64'd0); check({63'd0, bus.TakenInterrupt});

        bus.interrupt_sources = 8'h04;
        tick();
        want("cause_ip", 64'h0400); rd(5'd13, 3'd0, v); check(v);
        want("taken_int", 64'd1); check({63'd0, bus.TakenInterrupt});

        bus.next_pc = 64'h1000;
        tick();
        want("epc_int", 64'h1000); check(bus.EPC);
        want("status_exl", 64'hFF03); rd(5'd12, 3'd0, v); check(v);
        want("cause_int", 64'h0400); rd(5'd13, 3'd0, v); check(v);
        want("taken_masked", 64'd0); check({63'd0, bus.TakenInterrupt});

        bus.ERET = 1'b1;
        tick();
        bus.ERET = 1'b0;
        want("status_eret", 64'hFF01); rd(5'd12, 3'd0, v); check(v);
        want("taken_again", 64'd1); check({63'd0, bus.TakenInterrupt});
        want("epc_eret", 64'h1000); check(bus.EPC);

        bus.interrupt_sources = 8'h00;
        bus.overflow          = 1'b1;
        bus.reserved_inst     = 1'b1;
        bus.next_pc           = 64'h2000;
        want("taken_fault", 64'd1);
        #1 check({63'd0, bus.TakenInterrupt});
        tick();
        want("cause_ri", 64'h0028); rd(5'd13, 3'd0, v); check(v);
        want("epc_ri", 64'h2000); check(bus.EPC);
        want("taken_fault_exl", 64'd0); check({63'd0, bus.TakenInterrupt});
        bus.next_pc = 64'h3000;
        tick();
        want("epc_hold", 64'h2000); check(bus.EPC);
        bus.overflow      = 1'b0;
        bus.reserved_inst = 1'b0;

        mtc0(5'd12, 3'd0, 64'h0001);
        want("status_0001", 64'h0001); rd(5'd12, 3'd0, v); check(v);
        want("taken_im0", 64'd0); check({63'd0, bus.TakenInterrupt});

        mtc0(5'd14, 3'd0, 64'hDEADBEEF_00000040);
        want("epc_out_wr", 64'hDEADBEEF_00000040); check(bus.EPC);
        want("epc_rd_wr", 64'hDEADBEEF_00000040);
        rd(5'd14, 3'd0, v); check(v);

        mtc0(5'd13, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        want("cause_ro", 64'h0028); rd(5'd13, 3'd0, v); check(v);

        mtc0(5'd12, 3'd1, 64'hFFFF);
        want("status_sel1_wr", 64'h0001); rd(5'd12, 3'd0, v); check(v);
        want("status_sel1_rd", 64'd0); rd(5'd12, 3'd1, v); check(v);
        bus.sel = 3'd0;

        bus.syscall    = 1'b1;
        bus.break_inst = 1'b1;
        bus.next_pc    = 64'h4000;
        want("taken_sys", 64'd1);
        #1 check({63'd0, bus.TakenInterrupt});
        tick();
        bus.syscall    = 1'b0;
        bus.break_inst = 1'b0;
        want("cause_sys", 64'h0020); rd(5'd13, 3'd0, v); check(v);
        want("epc_sys", 64'h4000); check(bus.EPC);

        mtc0(5'd12, 3'd0, 64'h0001);
        bus.overflow = 1'b1;
        bus.ERET     = 1'b1;
        bus.next_pc  = 64'h5000;
        mtc0(5'd12, 3'd0, 64'hAA01);
        bus.overflow = 1'b0;
        bus.ERET     = 1'b0;
        want("status_race", 64'hAA03); rd(5'd12, 3'd0, v); check(v);
        want("cause_ov", 64'h0030); rd(5'd13, 3'd0, v); check(v);
        want("epc_race", 64'h5000); check(bus.EPC);

        bus.regnum = 5'd14;
        #2;
        reset = 1'b1;
        #1;
        want("arst_epc", 64'd0); check(bus.EPC);
        want("arst_taken", 64'd0); check({63'd0, bus.TakenInterrupt});
        want("arst_status", 64'd0); rd(5'd12, 3'd0, v); check(v);
        want("arst_cause", 64'd0); rd(5'd13, 3'd0, v); check(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
